// File: rtl/stream_sel_pkg.sv
// Shared types and helpers for the stream select arbiter slice.
// The FSM state type and the channel-index width helper live here.
package stream_sel_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Channel index width; never below 1 so index ports stay legal.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_select_arb_if.sv
// Stream bundle between N producers, the arbiter and one consumer.
// The slave modport is the arbiter's view of the bundle; the master modport is the environment's view.
interface stream_select_arb_if
  import stream_sel_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = sel_w(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: the first requester at or after ptr wins.
// Produces a one-hot grant, the winning index and an any-grant flag.
module rr_arbiter
  import stream_sel_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = sel_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              gnt_any
);

  // NOTE: every output gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SEL_W'(idx);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/stream_select_arb.sv
// N-channel registered stream arbiter with valid/ready backpressure and packet locking.
// Fixed-select or round-robin grant while idle; a started packet holds its channel until last.
module stream_select_arb
  import stream_sel_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
  input  logic [sel_w(NUM_CH)-1:0]   sel,
  stream_select_arb_if.slave         bus
);

  localparam int SEL_W = sel_w(NUM_CH);

  state_t            state;
  logic [SEL_W-1:0]  lock_ch;
  logic [SEL_W-1:0]  rr_ptr;

  logic [NUM_CH-1:0] rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic              rr_any;

  logic [NUM_CH-1:0] grant_vec;
  logic [SEL_W-1:0]  grant_idx;
  logic              load;
  logic              accept;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // The output register can take a beat when empty or draining this cycle.
  assign load = !bus.out_valid || bus.out_ready;

  always_comb begin
    grant_vec = '0;
    grant_idx = '0;
    if (state == ST_LOCKED) begin
      grant_idx            = lock_ch;
      grant_vec[lock_ch]   = 1'b1;
    end else if (mode) begin
      grant_idx = rr_idx;
      grant_vec = rr_any ? rr_gnt : '0;
    end else begin
      // Comparing against each legal index keeps an out-of-range sel from ever granting.
      for (int i = 0; i < NUM_CH; i++) begin
        if (sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_idx    = sel;
          grant_vec[i] = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready = (load && !rst) ? grant_vec : '0;
  assign accept       = |(bus.in_valid & bus.in_ready);
  assign acc_last     = bus.in_last[grant_idx];
  assign acc_data     = bus.in_data[grant_idx*DATA_W +: DATA_W];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only control and output registers are reset; there is no storage array here to clear.
      state         <= ST_IDLE;
      lock_ch       <= '0;
      rr_ptr        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_ch    <= '0;
    end else begin
      if (load) begin
        bus.out_valid <= accept;
        if (accept) begin
          bus.out_data <= acc_data;
          bus.out_last <= acc_last;
          bus.out_ch   <= grant_idx;
        end
      end
      if (accept) begin
        if (acc_last) begin
          state <= ST_IDLE;
          if (mode)
            rr_ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end else begin
          state   <= ST_LOCKED;
          lock_ch <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_select_arb.sv
// Directed, table-driven bench for stream_select_arb with NUM_CH=4, DATA_W=8.
// Each record drives one cycle, checks combinational in_ready, then the registered outputs after the edge.
module tb_stream_select_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [1:0] sel;

  int n_checks = 0;
  int n_fail   = 0;

  stream_select_arb_if #(.NUM_CH(4), .DATA_W(8)) bus ();

  stream_select_arb #(.NUM_CH(4), .DATA_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_last;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst           = v.rst;
    mode          = v.mode;
    sel           = v.sel;
    bus.in_valid  = v.valid;
    bus.in_last   = v.last;
    bus.in_data   = v.data;
    bus.out_ready = v.ordy;
    #1;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(v.exp_rdy));
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v.exp_valid));
    if (v.exp_valid || v.rst) begin
      check({tag, ".out_data"}, 32'(bus.out_data), 32'(v.exp_data));
      check({tag, ".out_last"}, 32'(bus.out_last), 32'(v.exp_last));
      check({tag, ".out_ch"},   32'(bus.out_ch),   32'(v.exp_ch));
    end
  endtask

  initial begin
    //          rst mode sel valid  last   data          ordy rdy    v  data   l  ch
    // Reset held two cycles with every channel valid.
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    // Fixed select of ch2, single beat, then an idle cycle empties the output.
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 4'h4, 4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 8'hA5, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
    // Round-robin over four always-valid single-beat channels.
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h2, 1'b1, 8'h11, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h4, 1'b1, 8'h12, 1'b1, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h8, 1'b1, 8'h13, 1'b1, 2'd3};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 4'hF, 4'hF, 32'h13121110, 1'b1, 4'h1, 1'b1, 8'h10, 1'b1, 2'd0};
    // ch1 3-beat packet with ch0 valid throughout; mode flipped mid-packet must not break the lock.
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 4'h3, 4'h0, 32'h00002120, 1'b1, 4'h2, 1'b1, 8'h21, 1'b0, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 2'd0, 4'h3, 4'h0, 32'h00002220, 1'b1, 4'h2, 1'b1, 8'h22, 1'b0, 2'd1};
    vecs[11] = '{1'b0, 1'b1, 2'd0, 4'h3, 4'h2, 32'h00002320, 1'b1, 4'h2, 1'b1, 8'h23, 1'b1, 2'd1};
    vecs[12] = '{1'b0, 1'b1, 2'd0, 4'h1, 4'h1, 32'h00000020, 1'b1, 4'h1, 1'b1, 8'h20, 1'b1, 2'd0};
    // Backpressure: beat 0x5C held three cycles, next beat 0x77 only accepted once drained.
    vecs[13] = '{1'b0, 1'b0, 2'd3, 4'h8, 4'h8, 32'h5C000000, 1'b1, 4'h8, 1'b1, 8'h5C, 1'b1, 2'd3};
    vecs[14] = '{1'b0, 1'b0, 2'd3, 4'h8, 4'h8, 32'h77000000, 1'b0, 4'h0, 1'b1, 8'h5C, 1'b1, 2'd3};
    vecs[15] = '{1'b0, 1'b0, 2'd3, 4'h8, 4'h8, 32'h77000000, 1'b0, 4'h0, 1'b1, 8'h5C, 1'b1, 2'd3};
    vecs[16] = '{1'b0, 1'b0, 2'd3, 4'h8, 4'h8, 32'h77000000, 1'b0, 4'h0, 1'b1, 8'h5C, 1'b1, 2'd3};
    vecs[17] = '{1'b0, 1'b0, 2'd3, 4'h8, 4'h8, 32'h77000000, 1'b1, 4'h8, 1'b1, 8'h77, 1'b1, 2'd3};
    vecs[18] = '{1'b0, 1'b0, 2'd3, 4'h0, 4'h0, 32'h00000000, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};

    for (int i = 0; i < 19; i++)
      apply(vecs[i], $sformatf("v%0d", i));

    // Mid-packet reset: lock on ch3, sel moves to 0 (lock holds), reset drops the lock, ch0 then wins.
    begin
      vec_t v;
      v = '{1'b0, 1'b0, 2'd3, 4'h8, 4'h0, 32'h31000000, 1'b1, 4'h8, 1'b1, 8'h31, 1'b0, 2'd3};
      apply(v, "rst_mid.lock");
      v = '{1'b0, 1'b0, 2'd0, 4'h9, 4'h0, 32'h32000040, 1'b1, 4'h8, 1'b1, 8'h32, 1'b0, 2'd3};
      apply(v, "rst_mid.held");
      v = '{1'b1, 1'b0, 2'd0, 4'h9, 4'h0, 32'h32000040, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0};
      apply(v, "rst_mid.rst");
      v = '{1'b0, 1'b0, 2'd0, 4'h9, 4'h1, 32'h33000040, 1'b1, 4'h1, 1'b1, 8'h40, 1'b1, 2'd0};
      apply(v, "rst_mid.after");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
